// File: rtl/ws_frame_scheduler.sv
// Frame scheduler for the ws2812 driver of the 16-pixel binary clock.
// Builds the pixel mask from BCD digits, snapshots mask/colour and paces frame strokes.
//
//  state      | meaning
//  -----------+-----------------------------------------------------
//  INIT       | ws_reset held high for INIT_CYCLES after reset
//  IDLE       | waiting for a change, pending change or refresh expiry
//  LOAD       | snapshot next mask and colour shadow
//  WRITE      | one-cycle ws_write stroke
//  WAIT_BUSY  | waiting for the driver to raise ws_busy
//  WAIT_DONE  | frame shifting out, waiting for ws_busy to fall
//  GAP        | post-frame latch gap of GAP_CYCLES
module ws_frame_scheduler #(
    parameter int unsigned NUM_LEDS    = 16,
    parameter int unsigned INIT_CYCLES = 600,
    parameter int unsigned GAP_CYCLES  = 720,
    parameter int unsigned REFRESH_CYC = 12000000,
    parameter int unsigned BUSY_TMO    = 16,
    parameter logic [23:0] COLOUR_RST  = 24'h101010
) (
    input  logic                hwclk_i,
    input  logic                reset_i,
    input  logic [23:0]         digits_i,
    input  logic                show_hours_i,
    input  logic [23:0]         colour_in_i,
    input  logic                colour_we_i,
    input  logic                ws_busy_i,
    output logic                ws_write_o,
    output logic                ws_reset_o,
    output logic [NUM_LEDS-1:0] led_mask_o,
    output logic [23:0]         rgb_colour_o,
    output logic                pending_o,
    output logic                ws_err_o
);

    localparam logic [2:0] S_INIT      = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_LOAD      = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;
    localparam logic [2:0] S_GAP       = 3'd6;

    localparam int unsigned CNT_MAX_IG = (INIT_CYCLES > GAP_CYCLES) ? INIT_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX    = (CNT_MAX_IG > BUSY_TMO) ? CNT_MAX_IG : BUSY_TMO;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned REF_W      = $clog2(REFRESH_CYC);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    // ws_err becomes visible exactly BUSY_TMO cycles after the write stroke
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TMO - 2);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYC - 1);

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REF_W-1:0]    ref_q, ref_d;
    logic [NUM_LEDS-1:0] mask_q, mask_d;
    logic [23:0]         colour_q, colour_d;
    logic [23:0]         shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic                err_q, err_d;

    logic [NUM_LEDS-1:0] next_mask;
    logic                refresh_exp;
    logic                trigger;

    always_comb begin
        next_mask = show_hours_i ? digits_i[23:8] : digits_i[15:0];
    end

    always_comb begin
        refresh_exp = (state_q == S_IDLE) && (ref_q == REF_LAST);
        trigger     = (next_mask != mask_q) || (shadow_q != colour_q) || refresh_exp;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        mask_d    = mask_q;
        colour_d  = colour_q;
        shadow_d  = colour_we_i ? colour_in_i : shadow_q;
        pending_d = pending_q;
        err_d     = err_q;

        case (state_q)
            S_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (ref_q != REF_LAST) begin
                    ref_d = ref_q + REF_W'(1);
                end
                // a stray busy from the driver defers the frame rather than dropping it
                if ((trigger || pending_q) && !ws_busy_i) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                mask_d   = next_mask;
                colour_d = shadow_q;
                ref_d    = '0;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                if (!ws_busy_i) begin
                    state_d = S_WAIT_BUSY;
                    cnt_d   = '0;
                end
            end
            S_WAIT_BUSY: begin
                if (ws_busy_i) begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == BUSY_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!ws_busy_i) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase

        if (state_d == S_LOAD) begin
            pending_d = 1'b0;
        end else if (trigger && (state_q != S_IDLE) && (state_q != S_LOAD)) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge hwclk_i) begin
        if (reset_i) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            ref_q     <= '0;
            mask_q    <= '0;
            colour_q  <= COLOUR_RST;
            shadow_q  <= COLOUR_RST;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            mask_q    <= mask_d;
            colour_q  <= colour_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign ws_reset_o   = (state_q == S_INIT);
    assign ws_write_o   = (state_q == S_WRITE) && !ws_busy_i;
    assign led_mask_o   = mask_q;
    assign rgb_colour_o = colour_q;
    assign pending_o    = pending_q;
    assign ws_err_o     = err_q;

endmodule

// File: tb/tb_ws_frame_scheduler.sv
// Directed bench for ws_frame_scheduler with shortened timing parameters.
module tb_ws_frame_scheduler;

    localparam int INIT_C = 20;
    localparam int GAP_C  = 30;
    localparam int REF_C  = 200;
    localparam int TMO    = 16;

    logic        hwclk = 1'b0;
    logic        reset;
    logic [23:0] digits;
    logic        show_hours;
    logic [23:0] colour_in;
    logic        colour_we;
    logic        ws_busy;
    logic        ws_write;
    logic        ws_reset;
    logic [15:0] led_mask;
    logic [23:0] rgb_colour;
    logic        pending;
    logic        ws_err;

    int cyc   = 0;
    int nwr   = 0;
    int tests = 0;
    int fails = 0;

    ws_frame_scheduler #(
        .NUM_LEDS   (16),
        .INIT_CYCLES(INIT_C),
        .GAP_CYCLES (GAP_C),
        .REFRESH_CYC(REF_C),
        .BUSY_TMO   (TMO),
        .COLOUR_RST (24'h101010)
    ) dut (
        .hwclk_i     (hwclk),
        .reset_i     (reset),
        .digits_i    (digits),
        .show_hours_i(show_hours),
        .colour_in_i (colour_in),
        .colour_we_i (colour_we),
        .ws_busy_i   (ws_busy),
        .ws_write_o  (ws_write),
        .ws_reset_o  (ws_reset),
        .led_mask_o  (led_mask),
        .rgb_colour_o(rgb_colour),
        .pending_o   (pending),
        .ws_err_o    (ws_err)
    );

    always #5 hwclk = ~hwclk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // cyc names the cycle that the following posedge closes; inputs change only at negedges
    always @(posedge hwclk) begin
        cyc <= cyc + 1;
        if (ws_write === 1'b1) begin
            nwr <= nwr + 1;
            chk("write_while_reset_or_busy", {30'd0, ws_reset, ws_busy}, 32'd0);
        end
    end

    task automatic tick();
        @(negedge hwclk);
    endtask

    task automatic wait_write(input string name, input int budget, output int wc);
        int i;
        i = 0;
        while (ws_write !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        if (ws_write !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s: no ws_write within %0d cycles", name, budget);
        end
        wc = cyc;
    endtask

    task automatic serve_frame(input int len, output int drop);
        tick();
        ws_busy = 1'b1;
        repeat (len) tick();
        ws_busy = 1'b0;
        drop = cyc;
    endtask

    // entered at a negedge with reset high; releases it and checks INIT and the first frame
    task automatic release_and_first_frame(input string tag, input logic [15:0] exp_mask);
        int n;
        n = 0;
        reset = 1'b0;
        while (ws_reset === 1'b1 && n < INIT_C + 10) begin
            n++;
            tick();
        end
        chk({tag, "_init_len"}, n, INIT_C);
        chk({tag, "_load_no_write"}, {31'd0, ws_write}, 32'd0);
        tick();
        chk({tag, "_first_write"}, {31'd0, ws_write}, 32'd1);
        chk({tag, "_first_mask"}, {16'd0, led_mask}, {16'd0, exp_mask});
        chk({tag, "_first_rgb"}, {8'd0, rgb_colour}, 32'h101010);
        chk({tag, "_first_pending"}, {31'd0, pending}, 32'd0);
    endtask

    typedef struct {
        logic [23:0] digits;
        logic        show;
        logic        cwe;
        logic [23:0] colour;
        int          lat;
        logic [15:0] mask;
        logic [23:0] rgb;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int wc;
        int w;
        int n_after;

        vecs[0] = '{24'h123459, 1'b0, 1'b0, 24'h000000, 2, 16'h3459, 24'h101010};
        vecs[1] = '{24'h123459, 1'b1, 1'b0, 24'h000000, 2, 16'h1234, 24'h101010};
        vecs[2] = '{24'h123459, 1'b1, 1'b0, 24'h000000, 0, 16'h1234, 24'h101010};
        vecs[3] = '{24'h123400, 1'b1, 1'b0, 24'h000000, 0, 16'h1234, 24'h101010};
        vecs[4] = '{24'hABCDEF, 1'b1, 1'b0, 24'h000000, 2, 16'hABCD, 24'h101010};
        vecs[5] = '{24'hABCDEF, 1'b0, 1'b0, 24'h000000, 2, 16'hCDEF, 24'h101010};
        vecs[6] = '{24'hABCDEF, 1'b0, 1'b1, 24'h0000FF, 3, 16'hCDEF, 24'h0000FF};
        vecs[7] = '{24'hABCDEF, 1'b0, 1'b1, 24'h0000FF, 0, 16'hCDEF, 24'h0000FF};
        vecs[8] = '{24'h000000, 1'b0, 1'b0, 24'h000000, 2, 16'h0000, 24'h0000FF};

        reset      = 1'b1;
        digits     = 24'h0;
        show_hours = 1'b0;
        colour_in  = 24'h0;
        colour_we  = 1'b0;
        ws_busy    = 1'b0;

        // reset values and power-up frame
        repeat (3) tick();
        chk("rst_ws_reset", {31'd0, ws_reset}, 32'd1);
        chk("rst_ws_write", {31'd0, ws_write}, 32'd0);
        chk("rst_mask", {16'd0, led_mask}, 32'd0);
        chk("rst_rgb", {8'd0, rgb_colour}, 32'h101010);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_err", {31'd0, ws_err}, 32'd0);
        release_and_first_frame("t1", 16'h0000);

        // periodic refresh with nothing changed
        serve_frame(5, d);
        wait_write("refresh", GAP_C + REF_C + 20, wc);
        chk("refresh_time", wc, d + GAP_C + REF_C + 2);
        chk("refresh_mask", {16'd0, led_mask}, 32'd0);
        serve_frame(5, d);
        repeat (GAP_C + 2) tick();

        // mask mapping and colour updates from IDLE
        for (int i = 0; i < 9; i++) begin
            digits     = vecs[i].digits;
            show_hours = vecs[i].show;
            if (vecs[i].cwe) begin
                colour_in = vecs[i].colour;
                colour_we = 1'b1;
            end
            for (int t = 1; t <= 3; t++) begin
                tick();
                if (t == 1) colour_we = 1'b0;
                if (vecs[i].lat == 0 || t <= vecs[i].lat) begin
                    chk($sformatf("vec%0d_write_t%0d", i, t), {31'd0, ws_write},
                        {31'd0, (t == vecs[i].lat)});
                end
                if (t == vecs[i].lat) begin
                    chk($sformatf("vec%0d_mask", i), {16'd0, led_mask}, {16'd0, vecs[i].mask});
                    chk($sformatf("vec%0d_rgb", i), {8'd0, rgb_colour}, {8'd0, vecs[i].rgb});
                    break;
                end
            end
            if (vecs[i].lat == 0) begin
                chk($sformatf("vec%0d_hold_mask", i), {16'd0, led_mask}, {16'd0, vecs[i].mask});
                chk($sformatf("vec%0d_no_pending", i), {31'd0, pending}, 32'd0);
            end else begin
                serve_frame(5, d);
                repeat (GAP_C + 2) tick();
            end
        end

        // s0 changes 5->6->7 while busy collapse into one frame
        digits = 24'h000005;
        tick();
        tick();
        chk("t3_write", {31'd0, ws_write}, 32'd1);
        chk("t3_mask5", {16'd0, led_mask}, 32'h0005);
        tick();
        ws_busy = 1'b1;
        tick();
        digits = 24'h000006;
        tick();
        chk("t3_pending", {31'd0, pending}, 32'd1);
        digits = 24'h000007;
        repeat (3) tick();
        ws_busy = 1'b0;
        d = cyc;
        wait_write("t3_extra", GAP_C + 20, wc);
        chk("t3_extra_time", wc, d + GAP_C + 3);
        chk("t3_extra_mask", {16'd0, led_mask}, 32'h0007);
        chk("t3_pending_clr", {31'd0, pending}, 32'd0);
        serve_frame(5, d);
        n_after = nwr;
        repeat (GAP_C + 20) tick();
        chk("t3_single_extra", nwr, n_after);

        // colour written mid-frame waits for the next LOAD
        digits = 24'h000008;
        tick();
        tick();
        chk("t5_write", {31'd0, ws_write}, 32'd1);
        chk("t5_rgb_old", {8'd0, rgb_colour}, 32'h0000FF);
        tick();
        ws_busy = 1'b1;
        tick();
        colour_in = 24'h00FF00;
        colour_we = 1'b1;
        tick();
        colour_we = 1'b0;
        chk("t5_rgb_held", {8'd0, rgb_colour}, 32'h0000FF);
        tick();
        chk("t5_pending", {31'd0, pending}, 32'd1);
        repeat (2) tick();
        ws_busy = 1'b0;
        d = cyc;
        wait_write("t5_next", GAP_C + 20, wc);
        chk("t5_next_time", wc, d + GAP_C + 3);
        chk("t5_rgb_new", {8'd0, rgb_colour}, 32'h00FF00);
        chk("t5_mask", {16'd0, led_mask}, 32'h0008);
        serve_frame(5, d);
        repeat (GAP_C + 2) tick();

        // busy never rises: timeout, gap, back to IDLE
        digits = 24'h000009;
        tick();
        tick();
        chk("t4_write", {31'd0, ws_write}, 32'd1);
        w = cyc;
        repeat (TMO - 1) tick();
        chk("t4_err_early", {31'd0, ws_err}, 32'd0);
        tick();
        chk("t4_err_time", cyc, w + TMO);
        chk("t4_err", {31'd0, ws_err}, 32'd1);
        repeat (GAP_C) tick();
        digits = 24'h000011;
        tick();
        chk("t4_idle_load", {31'd0, ws_write}, 32'd0);
        tick();
        chk("t4_idle_write", {31'd0, ws_write}, 32'd1);
        chk("t4_idle_mask", {16'd0, led_mask}, 32'h0011);
        serve_frame(5, d);
        repeat (GAP_C + 2) tick();
        chk("t4_err_sticky", {31'd0, ws_err}, 32'd1);

        // reset during WAIT_DONE
        digits = 24'h000010;
        tick();
        tick();
        chk("t6_write", {31'd0, ws_write}, 32'd1);
        tick();
        ws_busy = 1'b1;
        tick();
        digits = 24'h000012;
        tick();
        chk("t6_pending_pre", {31'd0, pending}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t6_ws_reset", {31'd0, ws_reset}, 32'd1);
        chk("t6_mask", {16'd0, led_mask}, 32'd0);
        chk("t6_pending", {31'd0, pending}, 32'd0);
        chk("t6_err", {31'd0, ws_err}, 32'd0);
        chk("t6_rgb", {8'd0, rgb_colour}, 32'h101010);
        ws_busy = 1'b0;
        release_and_first_frame("t6", 16'h0012);
        serve_frame(5, d);
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
